// File: rtl/data_mem_responder.sv
// Word-organised data memory answering a valid/ready load/store request channel
// on a valid/ready response channel after LATENCY wait states, one transaction at a time.
module data_mem_responder #(
   parameter int DEPTH   = 128,
   parameter int LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_wstrb_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_LOAD = 4'(LATENCY);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t           state;
   state_t           state_next;
   logic             write_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       wstrb_q;
   logic [3:0]       count;
   logic [31:0]      mem [DEPTH];
   logic             accept;
   logic             access;
   logic             access_err;
   logic [29:0]      word_index;
   logic [IDX_W-1:0] mem_index;

   // The counter holds the wait edges still to run; the access edge follows the last one,
   // so a request accepted at edge N responds after edge N+LATENCY+1 (LATENCY=0 included).
   assign accept     = (state == IDLE) && req_valid_i;
   assign access     = (state == BUSY) && (count == 4'd0);
   assign word_index = addr_q[31:2];
   assign mem_index  = word_index[IDX_W-1:0];
   assign access_err = (addr_q[1:0] != 2'b00) || (word_index >= 30'(DEPTH));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid_i) state_next = BUSY;
         BUSY:    if (count == 4'd0) state_next = RESP;
         RESP:    if (rsp_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      case (state)
         IDLE:    req_ready_o = 1'b1;
         RESP:    rsp_valid_o = 1'b1;
         default: ;
      endcase
   end

   // Request fields are captured only on the accepting edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         write_q <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         wstrb_q <= 4'h0;
         count   <= 4'd0;
      end else if (accept) begin
         write_q <= req_write_i;
         addr_q  <= req_addr_i;
         wdata_q <= req_wdata_i;
         wstrb_q <= req_wstrb_i;
         count   <= WAIT_LOAD;
      end else if ((state == BUSY) && (count != 4'd0)) begin
         count <= count - 4'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_rdata_o <= 32'h0;
         rsp_err_o   <= 1'b0;
      end else if (access) begin
         rsp_err_o   <= access_err;
         rsp_rdata_o <= (!write_q && !access_err) ? mem[mem_index] : 32'h0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'h0;
         end
      end else if (access && write_q && !access_err) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) begin
               mem[mem_index][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=2 instance for the main scenarios
// and a LATENCY=0 instance for the back-to-back timing.
module tb_data_mem_responder;
   localparam int DEPTH = 128;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [3:0]  req_wstrb;
   logic        req_valid_z, req_ready_z, req_write_z, rsp_valid_z, rsp_ready_z, rsp_err_z;
   logic [31:0] req_addr_z, req_wdata_z, rsp_rdata_z;
   logic [3:0]  req_wstrb_z;

   int          compared = 0;
   int          mismatched = 0;
   rsp_t        sb [$];
   logic [31:0] model [2][DEPTH];

   data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
   );

   data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut_zero (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid_z), .req_ready_o(req_ready_z), .req_write_i(req_write_z),
      .req_addr_i(req_addr_z), .req_wdata_i(req_wdata_z), .req_wstrb_i(req_wstrb_z),
      .rsp_valid_o(rsp_valid_z), .rsp_ready_i(rsp_ready_z),
      .rsp_rdata_o(rsp_rdata_z), .rsp_err_o(rsp_err_z)
   );

   task automatic clear_model();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < DEPTH; i++) begin
            model[m][i] = 32'h0;
         end
      end
   endtask

   // Reference behaviour of one access on memory copy m; stores update the copy.
   function automatic rsp_t model_access(input int m, input req_t r);
      rsp_t        res;
      logic [29:0] idx;
      idx       = r.addr[31:2];
      res.err   = (r.addr[1:0] != 2'b00) || (idx >= 30'(DEPTH));
      res.rdata = 32'h0;
      if (!res.err) begin
         if (r.wr) begin
            for (int b = 0; b < 4; b++) begin
               if (r.wstrb[b]) model[m][int'(idx)][8*b +: 8] = r.wdata[8*b +: 8];
            end
         end else begin
            res.rdata = model[m][int'(idx)];
         end
      end
      return res;
   endfunction

   // One full transaction on the LATENCY=2 instance; lat counts edges from accept to rsp_valid.
   task automatic transact(input req_t r, input logic early, output rsp_t got, output int lat,
                           output logic ok);
      int n;
      ok = 1'b1;
      n  = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (req_ready !== 1'b1) ok = 1'b0;
      req_valid = 1'b1;
      req_write = r.wr;
      req_addr  = r.addr;
      req_wdata = r.wdata;
      req_wstrb = r.wstrb;
      rsp_ready = early;
      sb.push_back(model_access(0, r));
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = ~r.wr;
      req_addr  = r.addr ^ 32'h4;
      req_wdata = ~r.wdata;
      req_wstrb = ~r.wstrb;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      if (rsp_valid !== 1'b1) ok = 1'b0;
      got       = {rsp_rdata, rsp_err};
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      req_t r;
      rsp_t got, exp;
      int   lat;
      logic ok;
      rst = 1'b1;
      #12;
      compared++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                  req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      compared++;
      if ({req_ready_z, rsp_valid_z, rsp_rdata_z, rsp_err_z} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs_lat0: got ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                  req_ready_z, rsp_valid_z, rsp_rdata_z, rsp_err_z);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      r = {1'b0, 32'h1FC, 32'h0, 4'h0};
      transact(r, 1'b0, got, lat, ok);
      exp = sb.pop_front();
      compared++;
      if (!ok || got !== exp) begin
         mismatched++;
         $display("[TB] FAIL reset_mem_clear: got rdata=%h err=%b ok=%b, want rdata=%h err=%b",
                  got.rdata, got.err, ok, exp.rdata, exp.err);
      end
   endtask

   task automatic test_store_load();
      req_t reqs [2];
      rsp_t got, exp;
      int   lat;
      logic ok;
      reqs[0] = {1'b1, 32'h10, 32'hDEADBEEF, 4'hF};
      reqs[1] = {1'b0, 32'h10, 32'h0, 4'h0};
      foreach (reqs[i]) begin
         transact(reqs[i], 1'b0, got, lat, ok);
         compared++;
         if (ok !== 1'b1 || lat != 3) begin
            mismatched++;
            $display("[TB] FAIL store_load_latency[%0d]: got %0d edges ok=%b, want 3", i, lat, ok);
         end
         exp = sb.pop_front();
         compared++;
         if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL store_load_rsp[%0d]: got rdata=%h err=%b, want rdata=%h err=%b",
                     i, got.rdata, got.err, exp.rdata, exp.err);
         end
      end
      compared++;
      if (got !== {32'hDEADBEEF, 1'b0}) begin
         mismatched++;
         $display("[TB] FAIL store_load_value: got rdata=%h err=%b, want deadbeef 0", got.rdata, got.err);
      end
   endtask

   task automatic test_byte_strobes();
      req_t reqs [5];
      rsp_t got, exp;
      int   lat;
      logic ok;
      reqs[0] = {1'b1, 32'h20, 32'h11223344, 4'hF};
      reqs[1] = {1'b1, 32'h20, 32'hAABBCCDD, 4'b0101};
      reqs[2] = {1'b0, 32'h20, 32'h0, 4'h0};
      reqs[3] = {1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000};
      reqs[4] = {1'b0, 32'h20, 32'h0, 4'h0};
      foreach (reqs[i]) begin
         transact(reqs[i], 1'b0, got, lat, ok);
         exp = sb.pop_front();
         compared++;
         if (!ok || lat != 3 || got !== exp) begin
            mismatched++;
            $display("[TB] FAIL strobe_rsp[%0d]: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=3",
                     i, got.rdata, got.err, lat, exp.rdata, exp.err);
         end
      end
      compared++;
      if (got.rdata !== 32'h11BB33DD) begin
         mismatched++;
         $display("[TB] FAIL strobe_value: got %h, want 11bb33dd", got.rdata);
      end
   endtask

   task automatic test_errors();
      req_t reqs [6];
      rsp_t got, exp;
      int   lat;
      logic ok;
      reqs[0] = {1'b1, 32'h22, 32'h99999999, 4'hF};
      reqs[1] = {1'b0, 32'h20, 32'h0, 4'h0};
      reqs[2] = {1'b0, 32'h200, 32'h0, 4'h0};
      reqs[3] = {1'b0, 32'h1FC, 32'h0, 4'h0};
      reqs[4] = {1'b1, 32'h1FC, 32'h0BADF00D, 4'hF};
      reqs[5] = {1'b0, 32'h1FC, 32'h0, 4'h0};
      foreach (reqs[i]) begin
         transact(reqs[i], 1'b1, got, lat, ok);
         exp = sb.pop_front();
         compared++;
         if (!ok || lat != 3 || got !== exp) begin
            mismatched++;
            $display("[TB] FAIL error_rsp[%0d]: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=3",
                     i, got.rdata, got.err, lat, exp.rdata, exp.err);
         end
         if (i == 2) begin
            compared++;
            if (got !== {32'h0, 1'b1}) begin
               mismatched++;
               $display("[TB] FAIL error_out_of_range: got rdata=%h err=%b, want 0 1", got.rdata, got.err);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      req_t first, second;
      rsp_t held, got, exp;
      int   n;
      first  = {1'b0, 32'h10, 32'h0, 4'h0};
      second = {1'b0, 32'h20, 32'h0, 4'h0};
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      {req_write, req_addr, req_wdata, req_wstrb} = {first.wr, first.addr, first.wdata, first.wstrb};
      sb.push_back(model_access(0, first));
      @(posedge clk); #1;
      {req_write, req_addr, req_wdata, req_wstrb} = {second.wr, second.addr, second.wdata, second.wstrb};
      sb.push_back(model_access(0, second));
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      held = {rsp_rdata, rsp_err};
      exp  = sb.pop_front();
      compared++;
      if (n != 3 || held !== exp) begin
         mismatched++;
         $display("[TB] FAIL bp_first_rsp: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=3",
                  held.rdata, held.err, n, exp.rdata, exp.err);
      end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         compared++;
         if ({rsp_valid, req_ready, rsp_rdata, rsp_err} !== {1'b1, 1'b0, held}) begin
            mismatched++;
            $display("[TB] FAIL bp_hold[%0d]: got valid=%b ready=%b rdata=%h, want 1 0 %h",
                     c, rsp_valid, req_ready, rsp_rdata, held.rdata);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      compared++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
         mismatched++;
         $display("[TB] FAIL bp_after_handshake: got ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      compared++;
      if (req_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL bp_next_accept: got ready=%b, want 0", req_ready);
      end
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      got = {rsp_rdata, rsp_err};
      exp = sb.pop_front();
      compared++;
      if (n != 3 || got !== exp) begin
         mismatched++;
         $display("[TB] FAIL bp_second_rsp: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=3",
                  got.rdata, got.err, n, exp.rdata, exp.err);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      req_t r;
      rsp_t got, exp;
      int   lat;
      logic ok;
      req_valid = 1'b1;
      {req_write, req_addr, req_wdata, req_wstrb} = {1'b1, 32'h30, 32'h55AA55AA, 4'hF};
      @(posedge clk); #1;
      req_valid = 1'b0;
      compared++;
      if (req_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rst_mid_busy: got ready=%b, want 0", req_ready);
      end
      #2 rst = 1'b1;
      #1;
      compared++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
         mismatched++;
         $display("[TB] FAIL rst_mid_immediate: got ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
      end
      #2 rst = 1'b0;
      clear_model();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         compared++;
         if ({req_ready, rsp_valid} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL rst_mid_dropped[%0d]: got ready=%b valid=%b, want 1 0", c, req_ready, rsp_valid);
         end
      end
      r = {1'b0, 32'h30, 32'h0, 4'h0};
      transact(r, 1'b0, got, lat, ok);
      exp = sb.pop_front();
      compared++;
      if (!ok || got !== exp || got.rdata !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL rst_mid_load: got rdata=%h err=%b ok=%b, want rdata=%h err=%b",
                  got.rdata, got.err, ok, exp.rdata, exp.err);
      end
   endtask

   // Expected LATENCY=0 rhythm before each edge: IDLE/accept, BUSY, RESP/handshake.
   task automatic test_latency_zero();
      req_t reqs [4];
      rsp_t exp;
      int   k;
      logic exp_ready, exp_valid;
      reqs[0] = {1'b1, 32'h40, 32'hCAFEF00D, 4'hF};
      reqs[1] = {1'b0, 32'h40, 32'h0, 4'h0};
      reqs[2] = {1'b0, 32'h200, 32'h0, 4'h0};
      reqs[3] = {1'b0, 32'h42, 32'h0, 4'h0};
      rsp_ready_z = 1'b1;
      req_valid_z = 1'b1;
      {req_write_z, req_addr_z, req_wdata_z, req_wstrb_z} = reqs[0];
      for (int e = 0; e < 12; e++) begin
         exp_ready = (e % 3 == 0);
         exp_valid = (e % 3 == 2);
         compared++;
         if ({req_ready_z, rsp_valid_z} !== {exp_ready, exp_valid}) begin
            mismatched++;
            $display("[TB] FAIL lat0_timing[%0d]: got ready=%b valid=%b, want %b %b",
                     e, req_ready_z, rsp_valid_z, exp_ready, exp_valid);
         end
         if (rsp_valid_z === 1'b1) begin
            compared++;
            if (sb.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL lat0_rsp[%0d]: got unexpected response, want none", e);
            end else begin
               exp = sb.pop_front();
               if ({rsp_rdata_z, rsp_err_z} !== exp) begin
                  mismatched++;
                  $display("[TB] FAIL lat0_rsp[%0d]: got rdata=%h err=%b, want rdata=%h err=%b",
                           e, rsp_rdata_z, rsp_err_z, exp.rdata, exp.err);
               end
            end
         end
         k = e / 3;
         if (req_ready_z === 1'b1 && k < 4) sb.push_back(model_access(1, reqs[k]));
         @(posedge clk); #1;
         if (e % 3 == 0 && k + 1 < 4) begin
            {req_write_z, req_addr_z, req_wdata_z, req_wstrb_z} = reqs[k + 1];
         end
      end
      req_valid_z = 1'b0;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL lat0_drain: got %0d responses outstanding, want 0", sb.size());
      end
   endtask

   initial begin
      rst         = 1'b1;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_addr    = 32'h0;
      req_wdata   = 32'h0;
      req_wstrb   = 4'h0;
      rsp_ready   = 1'b0;
      req_valid_z = 1'b0;
      req_write_z = 1'b0;
      req_addr_z  = 32'h0;
      req_wdata_z = 32'h0;
      req_wstrb_z = 4'h0;
      rsp_ready_z = 1'b0;
      clear_model();
      test_reset();
      test_store_load();
      test_byte_strobes();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_latency_zero();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
